ap_result_collector: RTL
========================

// Module: ap_result_collector
// PURPOSE
//  Downstream stage of the vector x vector / matrix x vector dot-product unit.
//  Captures each scalar dot-product result, qualified by its one-cycle finish strobe.
//  Packs no_of_units consecutive results into one row word.
//  Writes each complete word to the AP_total memory with a one-cycle write-enable pulse.
//  Raises done once every equation of the cluster has been stored.
// PARAMETERS
//  number_of_equations_per_cluster  16  results (equations) expected per run
//  element_width                    32  bits per result (IEEE-754 single, passed through untouched)
//  no_of_units                       8  results (lanes) per memory word
//  addr_width                        8  AP_total memory address width
//  words  (localparam)  ceil(number_of_equations_per_cluster/no_of_units)  words written per run
// PORTS
//  clk            in   1                        rising-edge clock
//  reset          in   1                        synchronous, active-low reset
//  start          in   1                        pulse: arm a new collection run
//  result         in   element_width            dot-product result
//  finish         in   1                        result valid this cycle (one-cycle pulse)
//  mem_we         out  1                        AP_total write enable (one-cycle pulse)
//  mem_addr       out  addr_width               word address, 0..words-1
//  mem_wdata      out  element_width*no_of_units  packed word; lane k at [k*W +: W]
//  eq_count       out  32                       results captured in the current run
//  done           out  1                        run complete; held high
// BEHAVIOUR
//  Reset: reset==0 at a rising edge forces the following, regardless of state:
//   - state IDLE; mem_we=0; mem_addr=0; mem_wdata=0; eq_count=0; done=0.
//   - pack buffer and lane counter cleared.
//  FSM states: IDLE, COLLECT, DONE.
//   - IDLE -> COLLECT on start; clears eq_count, lane counter, buffer, mem_addr and done.
//   - COLLECT: each finish writes result into lane lane_cnt, then lane_cnt++ and eq_count++.
//   - Word complete when lane_cnt==no_of_units-1 or eq_count==N-1 at the capture.
//   - On word complete, the next cycle shows mem_we=1 with mem_wdata = packed word.
//   - Unfilled lanes of the final partial word are zero.
//   - mem_addr advances after each write.
//   - Buffer and lane_cnt clear in the capture cycle, so finish on the cycle right after
//     a completing capture is accepted (back-to-back results, no stall).
//   - COLLECT -> DONE in the cycle mem_we pulses for word words-1. done=1 from the next cycle.
//   - DONE -> COLLECT on start, which re-arms as from IDLE.
//  Latency: completing finish at cycle t -> mem_we at t+1. No backpressure; memory always accepts.
//  Boundaries:
//   - finish in IDLE or DONE is ignored.
//   - start while in COLLECT is ignored.
//   - start and finish in the same cycle in IDLE/DONE: the run arms and the finish is dropped.
//   - N an exact multiple of no_of_units: no padding word is emitted.
//   - Reset mid-run discards the partial word; no write is issued.
//  mem_wdata holds its last value when mem_we=0.
// CONFIGURATION
//  AP_COLLECT_STATUS_EN defined:
//   - Adds output err_stray (1 bit), reset 0.
//   - Set sticky on any finish arriving in IDLE or DONE; cleared only by start or reset.
//  AP_COLLECT_STATUS_EN undefined:
//   - No err_stray port.
//   - Stray finish is silently ignored; all other behaviour is identical.
// STRUCTURE
//  Shared package vxv_pkg:
//   - FSM state encodings AP_IDLE=2'd0, AP_COLLECT=2'd1, AP_DONE=2'd2.
//   - ceil-divide constant function used for words.
//   - Default element_width and no_of_units.
//  Sub-module ap_lane_packer: lane-indexed capture register plus zero-clear. FSM, counters and
//  memory interface stay in the top.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles mid-run -> all outputs 0, state IDLE, no mem_we.
//  2 N=16, units=8: start, then 16 back-to-back finish with result=i+1
//    -> mem_we at addr 0 with lanes 1..8, and at addr 1 with lanes 9..16, each one cycle
//       after the 8th/16th capture -> done=1.
//  3 N=12, units=8: 12 results spaced 3 cycles apart
//    -> addr 1 word = lanes 9..12, lanes 4..7 equal 0 -> 2 writes total, then done.
//  4 Stray finish in DONE, then start + 16 results -> second run rewrites addr 0 and 1.
//    With AP_COLLECT_STATUS_EN: err_stray=1 until start.
//  5 Start asserted again at eq_count=5 -> ignored; run finishes normally; eq_count=16.
//  6 Reset after 10 captures, then a new run of 16 -> only 2 writes appear after the new start.

Source files
------------

// File: rtl/vxv_pkg.sv
// Shared definitions for the vector x vector / matrix x vector dot-product unit.
package vxv_pkg;

  typedef enum logic [1:0] {
    AP_IDLE    = 2'd0,
    AP_COLLECT = 2'd1,
    AP_DONE    = 2'd2
  } ap_state_t;

  localparam int VXV_ELEMENT_WIDTH = 32;
  localparam int VXV_NO_OF_UNITS   = 8;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ap_result_collector_if.sv
// Result-in / AP_total-write-out bundle of the result collector.
// err_stray exists only when AP_COLLECT_STATUS_EN is defined.
interface ap_result_collector_if
  import vxv_pkg::*;
#(
  parameter int element_width = VXV_ELEMENT_WIDTH,
  parameter int no_of_units   = VXV_NO_OF_UNITS,
  parameter int addr_width    = 8
);

  logic                                 start;
  logic [element_width-1:0]             result;
  logic                                 finish;
  logic                                 mem_we;
  logic [addr_width-1:0]                mem_addr;
  logic [element_width*no_of_units-1:0] mem_wdata;
  logic [31:0]                          eq_count;
  logic                                 done;
`ifdef AP_COLLECT_STATUS_EN
  logic                                 err_stray;
`endif

  // Collector side.
  modport slave (
    input  start, result, finish,
    output mem_we, mem_addr, mem_wdata, eq_count, done
`ifdef AP_COLLECT_STATUS_EN
    , output err_stray
`endif
  );

  // Dot-product engine / memory side.
  modport master (
    output start, result, finish,
    input  mem_we, mem_addr, mem_wdata, eq_count, done
`ifdef AP_COLLECT_STATUS_EN
    , input err_stray
`endif
  );

endinterface

// File: rtl/ap_lane_packer.sv
// Lane-indexed capture register: builds one row word from consecutive results.
// Latency: word_next is combinational (buffer with the current lane inserted).
// Backpressure: none; flush and clear zero the buffer in the capture cycle.
module ap_lane_packer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  localparam int lane_w       = (no_of_units > 1) ? $clog2(no_of_units) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 capture,
  input  logic                                 flush,
  input  logic [lane_w-1:0]                    lane,
  input  logic [element_width-1:0]             result,
  output logic [element_width*no_of_units-1:0] word_next
);

  logic [element_width*no_of_units-1:0] buffer;

  always_comb begin
    word_next = buffer;
    word_next[int'(lane)*element_width +: element_width] = result;
  end

  // Flushing clears in the same cycle so the next result may land in lane 0 immediately.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      buffer <= '0;
    end else if (capture) begin
      buffer <= flush ? '0 : word_next;
    end
  end

endmodule

// File: rtl/ap_result_collector.sv
// Packs dot-product results into AP_total row words and flags run completion.
// Latency: completing finish at cycle t gives mem_we at t+1. No backpressure.
// AP_COLLECT_STATUS_EN adds the sticky err_stray flag for finish outside a run.
module ap_result_collector
  import vxv_pkg::*;
#(
  parameter int number_of_equations_per_cluster = 16,
  parameter int element_width                   = VXV_ELEMENT_WIDTH,
  parameter int no_of_units                     = VXV_NO_OF_UNITS,
  parameter int addr_width                      = 8
) (
  input logic                  clk,
  input logic                  reset,
  ap_result_collector_if.slave bus
);

  localparam int words  = ceil_div(number_of_equations_per_cluster, no_of_units);
  localparam int lane_w = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam int word_w = element_width * no_of_units;

  ap_state_t             state;
  logic [lane_w-1:0]     lane_cnt;
  logic [31:0]           eq_count;
  logic                  mem_we;
  logic [addr_width-1:0] mem_addr;
  logic [word_w-1:0]     mem_wdata;
  logic                  done;

  logic [word_w-1:0]     word_next;
  logic                  arm;
  logic                  capture;
  logic                  word_cmpl;
  logic                  last_write;

  always_comb begin
    arm        = bus.start && (state != AP_COLLECT);
    // Results beyond the cluster size are not captured while the last word drains.
    capture    = bus.finish && (state == AP_COLLECT) &&
                 (eq_count != 32'(number_of_equations_per_cluster));
    word_cmpl  = capture &&
                 ((lane_cnt == lane_w'(no_of_units - 1)) ||
                  (eq_count == 32'(number_of_equations_per_cluster - 1)));
    last_write = mem_we && (mem_addr == addr_width'(words - 1));
  end

  ap_lane_packer #(
    .element_width (element_width),
    .no_of_units   (no_of_units)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (arm),
    .capture   (capture),
    .flush     (word_cmpl),
    .lane      (lane_cnt),
    .result    (bus.result),
    .word_next (word_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= AP_IDLE;
      lane_cnt  <= '0;
      eq_count  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      mem_we <= word_cmpl;
      if (word_cmpl) begin
        mem_wdata <= word_next;
      end
      case (state)
        AP_IDLE, AP_DONE: begin
          if (arm) begin
            state    <= AP_COLLECT;
            lane_cnt <= '0;
            eq_count <= '0;
            mem_addr <= '0;
            done     <= 1'b0;
          end
        end
        AP_COLLECT: begin
          if (capture) begin
            eq_count <= eq_count + 32'd1;
            lane_cnt <= word_cmpl ? '0 : lane_cnt + 1'b1;
          end
          // The address stays on the final word once the run is complete.
          if (last_write) begin
            state <= AP_DONE;
            done  <= 1'b1;
          end else if (mem_we) begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: state <= AP_IDLE;
      endcase
    end
  end

`ifdef AP_COLLECT_STATUS_EN
  logic err_stray;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_stray <= 1'b0;
    end else if (arm) begin
      err_stray <= 1'b0;
    end else if (bus.finish && (state != AP_COLLECT)) begin
      err_stray <= 1'b1;
    end
  end

  assign bus.err_stray = err_stray;
`endif

  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.eq_count  = eq_count;
  assign bus.done      = done;

endmodule
